// File: rtl/p1v_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Package : p1v_clk_pkg
//  Purpose : Shared definitions for the clock-switch sequencer: field
//            positions inside the CLK register / cfg word, CLKSEL source
//            encodings, the sequencer state type and a small max helper.
//  Ports   : (none - package)
//  Rev     : 1.0  initial release
// ============================================================================
package p1v_clk_pkg;

  // Widths of the CLK write word and of the cfg word sent to the generator
  localparam int WR_W  = 8;
  localparam int CFG_W = 7;

  // Bit positions (shared by wr_data[6:0] and cfg[6:0])
  localparam int WR_RESET      = 7;
  localparam int CFG_PLLENA    = 6;
  localparam int CFG_OSCENA    = 5;
  localparam int CFG_OSCM_HI   = 4;
  localparam int CFG_OSCM_LO   = 3;
  localparam int CFG_CLKSEL_HI = 2;
  localparam int CFG_CLKSEL_LO = 0;

  // CLKSEL source encodings
  localparam logic [2:0] CLKSEL_RCFAST = 3'd0;
  localparam logic [2:0] CLKSEL_RCSLOW = 3'd1;
  localparam logic [2:0] CLKSEL_XINPUT = 3'd2;
  localparam logic [2:0] CLKSEL_PLL1X  = 3'd3;
  localparam logic [2:0] CLKSEL_PLL2X  = 3'd4;
  localparam logic [2:0] CLKSEL_PLL4X  = 3'd5;
  localparam logic [2:0] CLKSEL_PLL8X  = 3'd6;
  localparam logic [2:0] CLKSEL_PLL16X = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENABLE  = 3'd1,
    SETTLE  = 3'd2,
    SWITCH  = 3'd3,
    HOLD    = 3'd4,
    DISABLE = 3'd5,
    ACK     = 3'd6
  } seq_state_t;

  // Largest of three values; sizes the shared settle/hold counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage : p1v_clk_pkg
`default_nettype wire

// File: rtl/clock_switch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface : clock_switch_sequencer_if
//  Purpose   : CLK-register write handshake plus the sequencer's status and
//              cfg outputs.
//  Signals   : wr_req    - write request, held with wr_data until wr_ack
//              wr_data   - [7]=RESET [6]=PLLENA [5]=OSCENA [4:3]=OSCM [2:0]=CLKSEL
//              wr_ack    - one-cycle pulse, write fully applied
//              cfg       - config word to the clock generator
//              busy      - sequencer not idle
//              reset_req - one-cycle chip-reset request
//  Modports  : master (hub side), slave (sequencer side)
//  Rev       : 1.0  initial release
// ============================================================================
interface clock_switch_sequencer_if;
  import p1v_clk_pkg::*;

  logic             wr_req;
  logic [WR_W-1:0]  wr_data;
  logic             wr_ack;
  logic [CFG_W-1:0] cfg;
  logic             busy;
  logic             reset_req;

  modport master (
    output wr_req, wr_data,
    input  wr_ack, cfg, busy, reset_req
  );

  modport slave (
    input  wr_req, wr_data,
    output wr_ack, cfg, busy, reset_req
  );

endinterface : clock_switch_sequencer_if
`default_nettype wire

// File: rtl/clock_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module  : clock_settle_timer
//  Purpose : Loadable down-counter shared by the settle and hold waits.
//            A load of N makes done_o rise after N enabled decrements;
//            the count saturates at zero and never wraps.
//  Ports   : clock      - free-running clock
//            nres       - asynchronous active-low reset
//            load_i     - load load_val_i (has priority over en_i)
//            load_val_i - value to load
//            en_i       - decrement when non-zero
//            done_o     - count is zero
//  Rev     : 1.0  initial release
// ============================================================================
module clock_settle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             nres,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule : clock_settle_timer
`default_nettype wire

// File: rtl/clock_switch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : clock_switch_sequencer
//  Purpose : Applies a CLK-register write to the clock generator cfg word in
//            a safe order: enable the oscillator/PLL first, wait for them to
//            settle, switch CLKSEL, hold, then drop enables no longer needed.
//  Ports   : clock - 160MHz free-running clock
//            nres  - asynchronous active-low reset
//            bus   - write handshake, cfg, busy and reset_req (slave modport)
//  Rev     : 1.0  initial release
// ============================================================================
module clock_switch_sequencer
  import p1v_clk_pkg::*;
#(
  parameter int unsigned      OSC_SETTLE  = 1_600_000,
  parameter int unsigned      PLL_SETTLE  = 16_000,
  parameter int unsigned      SWITCH_HOLD = 8,
  parameter logic [CFG_W-1:0] RESET_CFG   = 7'h00
) (
  input  logic                     clock,
  input  logic                     nres,
  clock_switch_sequencer_if.slave  bus
);

  localparam int unsigned CNT_MAX = max3(OSC_SETTLE, PLL_SETTLE, SWITCH_HOLD);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] OSC_CNT       = CNT_W'(OSC_SETTLE);
  localparam logic [CNT_W-1:0] PLL_CNT       = CNT_W'(PLL_SETTLE);
  localparam logic [CNT_W-1:0] HOLD_CNT_LOAD = CNT_W'(SWITCH_HOLD - 1);

  seq_state_t       state_q, state_d;
  logic [WR_W-1:0]  tgt_q, tgt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             ack_q, ack_d;
  logic             rst_req_q, rst_req_d;
  logic             busy_q, busy_d;

  logic             osc_need_w;
  logic             pll_need_w;
  logic [CNT_W-1:0] wait_w;

  logic             tmr_load_w;
  logic [CNT_W-1:0] tmr_val_w;
  logic             tmr_en_w;
  logic             tmr_done_w;

  // Settle requirement is judged against what the generator currently has
  // (cfg_q) versus what the write asks for (tgt_q). An OSCM change only
  // matters when the oscillator will be running afterwards.
  always_comb begin
    osc_need_w = tgt_q[CFG_OSCENA] &&
                 (!cfg_q[CFG_OSCENA] ||
                  (cfg_q[CFG_OSCM_HI:CFG_OSCM_LO] != tgt_q[CFG_OSCM_HI:CFG_OSCM_LO]));
    pll_need_w = tgt_q[CFG_PLLENA] && !cfg_q[CFG_PLLENA];
    wait_w     = '0;
    if (osc_need_w) wait_w = OSC_CNT;
    if (pll_need_w && (PLL_CNT > wait_w)) wait_w = PLL_CNT;
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cfg_d      = cfg_q;
    ack_d      = 1'b0;
    rst_req_d  = 1'b0;
    tmr_load_w = 1'b0;
    tmr_val_w  = '0;
    tmr_en_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          tgt_d   = bus.wr_data;
          state_d = ENABLE;
        end
      end

      ENABLE: begin
        // Only ever turn sources on here; CLKSEL still points at the old one.
        cfg_d[CFG_PLLENA] = cfg_q[CFG_PLLENA] | tgt_q[CFG_PLLENA];
        cfg_d[CFG_OSCENA] = cfg_q[CFG_OSCENA] | tgt_q[CFG_OSCENA];
        cfg_d[CFG_OSCM_HI:CFG_OSCM_LO] = tgt_q[CFG_OSCM_HI:CFG_OSCM_LO];
        if (wait_w != '0) begin
          // Loaded with wait-1 so the SETTLE dwell is exactly wait cycles
          tmr_load_w = 1'b1;
          tmr_val_w  = wait_w - CNT_W'(1);
          state_d    = SETTLE;
        end else begin
          state_d = SWITCH;
        end
      end

      SETTLE: begin
        if (tmr_done_w) begin
          state_d = SWITCH;
        end else begin
          tmr_en_w = 1'b1;
        end
      end

      SWITCH: begin
        cfg_d[CFG_CLKSEL_HI:CFG_CLKSEL_LO] = tgt_q[CFG_CLKSEL_HI:CFG_CLKSEL_LO];
        if (tgt_q[CFG_CLKSEL_HI:CFG_CLKSEL_LO] != cfg_q[CFG_CLKSEL_HI:CFG_CLKSEL_LO]) begin
          tmr_load_w = 1'b1;
          tmr_val_w  = HOLD_CNT_LOAD;
          state_d    = HOLD;
        end else begin
          state_d = DISABLE;
        end
      end

      HOLD: begin
        if (tmr_done_w) begin
          state_d = DISABLE;
        end else begin
          tmr_en_w = 1'b1;
        end
      end

      DISABLE: begin
        cfg_d = tgt_q[CFG_W-1:0];
        // Registered outputs: set here so they are high during ACK
        ack_d     = 1'b1;
        rst_req_d = tgt_q[WR_RESET];
        state_d   = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge nres) begin
    if (!nres) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      cfg_q     <= RESET_CFG;
      ack_q     <= 1'b0;
      rst_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cfg_q     <= cfg_d;
      ack_q     <= ack_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
    end
  end

  clock_settle_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clock      (clock),
    .nres       (nres),
    .load_i     (tmr_load_w),
    .load_val_i (tmr_val_w),
    .en_i       (tmr_en_w),
    .done_o     (tmr_done_w)
  );

  assign bus.cfg       = cfg_q;
  assign bus.wr_ack    = ack_q;
  assign bus.reset_req = rst_req_q;
  assign bus.busy      = busy_q;

endmodule : clock_switch_sequencer
`default_nettype wire

// File: tb/tb_clock_switch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_clock_switch_sequencer
//  Purpose : Directed scoreboard bench for clock_switch_sequencer with
//            OSC_SETTLE=20, PLL_SETTLE=10, SWITCH_HOLD=4, RESET_CFG=0.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_clock_switch_sequencer;

  localparam int OSC_C  = 20;
  localparam int PLL_C  = 10;
  localparam int HOLD_C = 4;

  logic clock = 1'b0;
  logic nres  = 1'b0;
  always #5 clock = ~clock;

  clock_switch_sequencer_if bus_if ();

  clock_switch_sequencer #(
    .OSC_SETTLE  (OSC_C),
    .PLL_SETTLE  (PLL_C),
    .SWITCH_HOLD (HOLD_C),
    .RESET_CFG   (7'h00)
  ) dut (
    .clock (clock),
    .nres  (nres),
    .bus   (bus_if)
  );

  typedef struct {
    int         start;
    int         lat;
    logic [6:0] cfg;
    logic       rr;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;
  logic [6:0] hist  [0:63];
  logic       busyh [0:63];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected response per wr_ack pulse
  always @(negedge clock) begin
    exp_t e;
    if (nres && bus_if.wr_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_latency", 32'(cyc - e.start), 32'(e.lat));
        check("ack_cfg", 32'(bus_if.cfg), 32'(e.cfg));
        check("ack_reset_req", 32'(bus_if.reset_req), 32'(e.rr));
      end
    end else if (nres && bus_if.reset_req) begin
      check("stray_reset_req", 32'd1, 32'd0);
    end
  end

  // Issue one write at a negedge; cfg/busy of each following cycle is logged
  // in hist/busyh indexed by cycle offset from the request.
  task automatic do_write(input logic [7:0] d, input int lat, input logic [6:0] ecfg);
    exp_t e;
    bit   got;
    e.start = cyc;
    e.lat   = lat;
    e.cfg   = ecfg;
    e.rr    = d[7];
    exp_q.push_back(e);
    bus_if.wr_data = d;
    bus_if.wr_req  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      hist[k]  = bus_if.cfg;
      busyh[k] = bus_if.busy;
      if (bus_if.wr_ack) got = 1'b1;
      else @(negedge clock);
    end
    bus_if.wr_req = 1'b0;
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    @(negedge clock);
    check("idle_after_ack_busy", 32'(bus_if.busy), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    bit ack_seen;
    bus_if.wr_req  = 1'b0;
    bus_if.wr_data = 8'h00;

    // Reset state
    #12;
    check("reset_cfg", 32'(bus_if.cfg), 32'h00);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_ack", 32'(bus_if.wr_ack), 32'd0);
    @(negedge clock);
    nres = 1'b1;
    repeat (2) @(negedge clock);

    // 1: null write, minimum latency, no HOLD
    do_write(8'h00, 4, 7'h00);
    check("s1_busy_enable", 32'(busyh[1]), 32'd1);
    check("s1_cfg_mid", 32'(hist[3]), 32'h00);

    // 2: OSC+PLL on, PLL16X: settle 20, hold 4
    do_write(8'h6F, 1 + OSC_C + 1 + HOLD_C + 1 + 1, 7'h6F);
    check("s2_cfg_in_enable", 32'(hist[1]), 32'h00);
    check("s2_cfg_settle_first", 32'(hist[2]), 32'h68);
    check("s2_cfg_settle_last", 32'(hist[1 + OSC_C]), 32'h68);
    check("s2_cfg_switch_cycle", 32'(hist[2 + OSC_C]), 32'h68);
    check("s2_cfg_hold", 32'(hist[3 + OSC_C]), 32'h6F);

    // 3: back to RCFAST, enables dropped only after HOLD
    do_write(8'h00, 1 + 1 + HOLD_C + 1 + 1, 7'h00);
    check("s3_cfg_switch_cycle", 32'(hist[2]), 32'h67);
    check("s3_cfg_hold_first", 32'(hist[3]), 32'h60);
    check("s3_cfg_disable_cycle", 32'(hist[7]), 32'h60);

    // 5: reset request bit
    do_write(8'h80, 4, 7'h00);

    // 4: prepare XINPUT with OSC on, then add PLL only
    do_write(8'h2A, 1 + OSC_C + 1 + HOLD_C + 1 + 1, 7'h2A);
    check("s4_prep_cfg_settle", 32'(hist[2]), 32'h28);
    do_write(8'h6A, 1 + PLL_C + 1 + 1 + 1, 7'h6A);
    check("s4_cfg_settle", 32'(hist[2]), 32'h6A);
    check("s4_busy_settle", 32'(busyh[5]), 32'd1);

    // 6: abort by reset in SETTLE cycle 5
    nres = 1'b0;
    @(negedge clock);
    nres = 1'b1;
    repeat (2) @(negedge clock);
    bus_if.wr_data = 8'h6F;
    bus_if.wr_req  = 1'b1;
    repeat (6) @(negedge clock);
    check("s6_cfg_before_abort", 32'(bus_if.cfg), 32'h68);
    check("s6_busy_before_abort", 32'(bus_if.busy), 32'd1);
    nres          = 1'b0;
    bus_if.wr_req = 1'b0;
    #1;
    check("s6_cfg_abort", 32'(bus_if.cfg), 32'h00);
    check("s6_busy_abort", 32'(bus_if.busy), 32'd0);
    check("s6_ack_abort", 32'(bus_if.wr_ack), 32'd0);
    @(negedge clock);
    nres = 1'b1;
    ack_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus_if.wr_ack || bus_if.reset_req) ack_seen = 1'b1;
    end
    check("s6_no_ack_after_abort", 32'(ack_seen), 32'd0);
    check("s6_cfg_after_abort", 32'(bus_if.cfg), 32'h00);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_clock_switch_sequencer
`default_nettype wire
